// File: rtl/tri_fifo_pkg.sv
// Shared types and constants for the triangle FIFO controller.
package tri_fifo_pkg;

    localparam int unsigned VW        = 10;
    localparam int unsigned NV        = 6;
    localparam int unsigned DW        = VW * NV;
    localparam int unsigned DEF_DEPTH = 100;

    typedef logic [NV-1:0][VW-1:0] triangle_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic Clk,
    input  logic Reset_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_grant;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Reset to 1 so producer 0 wins the first tie.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            last_grant <= 1'b1;
        else if (gnt0)
            last_grant <= 1'b0;
        else if (gnt1)
            last_grant <= 1'b1;
    end

endmodule

// File: rtl/triangle_fifo_ctrl.sv
// Triangle FIFO RAM controller: round-robin write arbitration and a
// first-word-fall-through read sequencer over a registered-output RAM.
module triangle_fifo_ctrl
    import tri_fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AW       = 7,
    parameter int unsigned DW       = tri_fifo_pkg::DW,
    parameter int unsigned AF_LEVEL = 90
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          flush,
    input  logic          p0_valid,
    input  logic [DW-1:0] p0_data,
    output logic          p0_ready,
    input  logic          p1_valid,
    input  logic [DW-1:0] p1_data,
    output logic          p1_ready,
    output logic          ram_w_en,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_r_en,
    output logic [AW-1:0] ram_r_addr,
    output logic          ram_is_empty,
    output logic          ram_is_full,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          almost_full
);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          g0, g1, wr, rd;
    logic [AW:0]   count_next;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ram_is_empty = (count == '0);
    assign ram_is_full  = (count == (AW+1)'(DEPTH));

    rr_arb2 u_arb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .en      (!ram_is_full && !flush),
        .req0    (p0_valid),
        .req1    (p1_valid),
        .gnt0    (g0),
        .gnt1    (g1)
    );

    assign wr         = g0 | g1;
    assign p0_ready   = g0;
    assign p1_ready   = g1;
    assign ram_w_en   = wr;
    assign ram_w_addr = wr_ptr;
    assign ram_w_data = g0 ? p0_data : p1_data;

    // Count excludes the entry in the RAM output register, so a write into an
    // empty FIFO cannot be read back in the same cycle.
    assign rd         = !flush && !ram_is_empty && (!out_valid || out_ready);
    assign ram_r_en   = rd;
    assign ram_r_addr = rd_ptr;

    always_comb begin
        count_next = count;
        case ({wr, rd})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr) wr_ptr <= ptr_inc(wr_ptr);
            if (rd) rd_ptr <= ptr_inc(rd_ptr);
            count       <= count_next;
            out_valid   <= rd || (out_valid && !out_ready);
            almost_full <= (count_next >= (AW+1)'(AF_LEVEL));
        end
    end

endmodule

// File: tb/tb_triangle_fifo_ctrl.sv
// Self-checking bench for triangle_fifo_ctrl with a queue-based reference model.
module tb_triangle_fifo_ctrl;

    localparam int DEPTH = 100;
    localparam int AW    = 7;
    localparam int DW    = 60;
    localparam int AF    = 90;

    logic          Clk = 1'b0;
    logic          Reset_n, flush, p0_valid, p1_valid, out_ready;
    logic [DW-1:0] p0_data, p1_data;
    logic          p0_ready, p1_ready, ram_w_en, ram_r_en;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [DW-1:0] ram_w_data;
    logic          ram_is_empty, ram_is_full, out_valid, almost_full;
    logic [AW:0]   count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] head_exp;
    bit            hv;
    int            wp, rp;
    bit            lg;

    // Behavioural RAM with registered read data
    logic [DW-1:0] mem[0:127];
    logic [DW-1:0] rdq;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
        if (ram_r_en) rdq <= mem[ram_r_addr];
    end

    triangle_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .AF_LEVEL(AF)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .flush        (flush),
        .p0_valid     (p0_valid),
        .p0_data      (p0_data),
        .p0_ready     (p0_ready),
        .p1_valid     (p1_valid),
        .p1_data      (p1_data),
        .p1_ready     (p1_ready),
        .ram_w_en     (ram_w_en),
        .ram_w_addr   (ram_w_addr),
        .ram_w_data   (ram_w_data),
        .ram_r_en     (ram_r_en),
        .ram_r_addr   (ram_r_addr),
        .ram_is_empty (ram_is_empty),
        .ram_is_full  (ram_is_full),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic model_reset();
        q.delete();
        hv = 0;
        wp = 0;
        rp = 0;
        lg = 1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_almost_full"}, almost_full, 0);
        chk({tag, "_empty"}, ram_is_empty, 1);
        chk({tag, "_full"}, ram_is_full, 0);
        chk({tag, "_w_addr"}, ram_w_addr, 0);
        chk({tag, "_r_addr"}, ram_r_addr, 0);
        chk({tag, "_r_en"}, ram_r_en, 0);
    endtask

    // One clock cycle: entered just after a rising edge, checks at the falling edge.
    task automatic step(input bit v0, input logic [DW-1:0] d0, input bit v1,
                        input logic [DW-1:0] d1, input bit ordy, input bit fl);
        bit g0, g1, rd, full;
        int n;
        p0_valid = v0; p0_data = d0;
        p1_valid = v1; p1_data = d1;
        out_ready = ordy; flush = fl;
        #4;
        n    = q.size();
        full = (n == DEPTH);
        g0 = 0; g1 = 0;
        if (!full && !fl) begin
            if (v0 && v1) begin
                g0 = lg;
                g1 = !lg;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        rd = !fl && (n != 0) && (!hv || ordy);
        chk("p0_ready", p0_ready, g0);
        chk("p1_ready", p1_ready, g1);
        chk("w_en", ram_w_en, g0 | g1);
        chk("w_addr", ram_w_addr, wp);
        chk("r_en", ram_r_en, rd);
        chk("r_addr", ram_r_addr, rp);
        chk("count", count, n);
        chk("empty", ram_is_empty, n == 0);
        chk("full", ram_is_full, full);
        chk("out_valid", out_valid, hv);
        chk("almost_full", almost_full, n >= AF);
        if (g0 | g1) chk("w_data", ram_w_data, g0 ? d0 : d1);
        if (hv) chk("head", rdq, head_exp);
        if (fl) begin
            q.delete();
            wp = 0;
            rp = 0;
            hv = 0;
        end else begin
            if (rd) begin
                head_exp = q.pop_front();
                rp = (rp == DEPTH - 1) ? 0 : rp + 1;
                hv = 1;
            end else if (hv && ordy) begin
                hv = 0;
            end
            if (g0 | g1) begin
                q.push_back(g0 ? d0 : d1);
                wp = (wp == DEPTH - 1) ? 0 : wp + 1;
                lg = g1;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 0; flush = 0; p0_valid = 0; p1_valid = 0; out_ready = 0;
        p0_data = '0; p1_data = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_reset_state("reset");
        Reset_n = 1;

        // Single write into empty FIFO, then observe fall-through latency
        step(1, 60'h123, 0, '0, 0, 0);
        step(0, '0, 0, '0, 0, 0);
        step(0, '0, 0, '0, 0, 0);
        step(0, '0, 0, '0, 1, 0);
        step(0, '0, 0, '0, 0, 0);

        // Both producers valid: alternating grants
        for (int i = 0; i < 4; i++) step(1, rnd(), 1, rnd(), 0, 0);
        for (int i = 0; i < 4; i++) step(1, rnd(), 0, '0, 0, 0);
        chk("pre_flush_count", count, 7);
        chk("pre_flush_out_valid", out_valid, 1);
        step(1, rnd(), 1, rnd(), 1, 1);
        check_reset_state("post_flush");

        // Fill past full with the consumer stalled
        for (int i = 0; i < 110; i++) step(1, rnd(), $urandom_range(0, 1), rnd(), 0, 0);
        chk("full_count", count, DEPTH);
        chk("full_flag", ram_is_full, 1);

        // Drain down to 5, then write and pop in the same cycle
        for (int k = 0; k < 200 && q.size() != 5; k++) step(0, '0, 0, '0, 1, 0);
        chk("cnt_at5", count, 5);
        step(0, '0, 1, rnd(), 1, 0);
        chk("cnt_keep5", count, 5);

        // Random streaming across pointer wrap
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), rnd(), $urandom_range(0, 1), rnd(),
                 $urandom_range(0, 3) != 0, 0);

        // Asynchronous reset between clock edges
        for (int i = 0; i < 20; i++) step(1, rnd(), 1, rnd(), 0, 0);
        p0_valid = 0; p1_valid = 0;
        Reset_n = 0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        #3;
        Reset_n = 1;
        @(posedge Clk);
        #1;

        // Random traffic with occasional flush, then drain
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1), rnd(), $urandom_range(0, 1), rnd(),
                 $urandom_range(0, 1), $urandom_range(0, 49) == 0);
        for (int k = 0; k < 250 && (q.size() != 0 || hv); k++) step(0, '0, 0, '0, 1, 0);
        chk("drained_count", count, 0);
        chk("drained_out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
